// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and encodings for the forwarding/hazard unit: select codes,
// standard Tnew/Tuse values and the shadow-pipeline stage entry.
package fwd_hazard_unit_pkg;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_W  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_E  = 2'd3;

    localparam int unsigned TNEW_ALU  = 1;
    localparam int unsigned TNEW_LOAD = 2;
    localparam int unsigned TNEW_LINK = 0;

    localparam int unsigned TUSE_BRANCH     = 0;
    localparam int unsigned TUSE_ALU        = 1;
    localparam int unsigned TUSE_STORE_DATA = 2;

    // Entry fields are sized for the widest supported AW/TW; narrower values zero-extend.
    localparam int unsigned ENTRY_AW = 8;
    localparam int unsigned ENTRY_TW = 4;

    typedef struct packed {
        logic                valid;
        logic [ENTRY_AW-1:0] dst;
        logic [ENTRY_TW-1:0] tnew;
    } stageEntry_t;

    // One stage of ageing: the result gets one cycle closer, never below zero.
    function automatic stageEntry_t ageEntry(input stageEntry_t s);
        stageEntry_t r;
        r = s;
        if (s.tnew != '0) r.tnew = s.tnew - ENTRY_TW'(1);
        return r;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// D-stage request, pipeline result buses and forwarding/stall results of the hazard unit.
interface fwd_hazard_unit_if #(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NSRC = 2,
    parameter int unsigned TW   = 2
);
    logic               d_valid;
    logic [AW-1:0]      d_dst;
    logic [TW-1:0]      d_tnew;
    logic [NSRC*AW-1:0] d_src;
    logic [NSRC*TW-1:0] d_tuse;
    logic [NSRC*DW-1:0] rf_data;
    logic [DW-1:0]      e_data;
    logic [DW-1:0]      m_data;
    logic [DW-1:0]      w_data;
    logic               stat_clr;
    logic               stall;
    logic [NSRC*DW-1:0] fwd_data;
    logic [NSRC*2-1:0]  fwd_sel;
    logic [NSRC-1:0]    fwd_pend;
    logic [31:0]        stall_cnt;

    modport master (
        output d_valid, d_dst, d_tnew, d_src, d_tuse, rf_data,
               e_data, m_data, w_data, stat_clr,
        input  stall, fwd_data, fwd_sel, fwd_pend, stall_cnt
    );

    modport slave (
        input  d_valid, d_dst, d_tnew, d_src, d_tuse, rf_data,
               e_data, m_data, w_data, stat_clr,
        output stall, fwd_data, fwd_sel, fwd_pend, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit_src_sel.sv
// Per-operand hazard logic: youngest-match search over E/M/W, stall request,
// forwarding select and pending flag.
module fwd_src_sel
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5,
    parameter int unsigned TW = 2
) (
    input  logic [AW-1:0] src,
    input  logic [TW-1:0] tuse,
    input  logic [DW-1:0] rfData,
    input  logic [DW-1:0] eData,
    input  logic [DW-1:0] mData,
    input  logic [DW-1:0] wData,
    input  stageEntry_t   eStage,
    input  stageEntry_t   mStage,
    input  stageEntry_t   wStage,
    output logic          stallReq_c,
    output logic [DW-1:0] data_c,
    output logic [1:0]    sel_c,
    output logic          pend_c
);

    logic                srcLive;
    logic                hitE;
    logic                hitM;
    logic                hitW;
    logic                hit;
    logic [ENTRY_TW-1:0] hitTnew;
    logic [1:0]          hitSel;
    logic [DW-1:0]       hitData;

    assign srcLive = (src != '0);
    assign hitE    = srcLive && eStage.valid && (eStage.dst == ENTRY_AW'(src));
    assign hitM    = srcLive && mStage.valid && (mStage.dst == ENTRY_AW'(src));
    assign hitW    = srcLive && wStage.valid && (wStage.dst == ENTRY_AW'(src));

    // Only the youngest producer counts, so an older ready copy never masks a newer pending one.
    always_comb begin
        hit     = 1'b0;
        hitTnew = '0;
        hitSel  = FWD_RF;
        hitData = rfData;
        if (hitE) begin
            hit = 1'b1; hitTnew = eStage.tnew; hitSel = FWD_E; hitData = eData;
        end else if (hitM) begin
            hit = 1'b1; hitTnew = mStage.tnew; hitSel = FWD_M; hitData = mData;
        end else if (hitW) begin
            hit = 1'b1; hitTnew = wStage.tnew; hitSel = FWD_W; hitData = wData;
        end
    end

    always_comb begin
        stallReq_c = 1'b0;
        pend_c     = 1'b0;
        sel_c      = FWD_RF;
        data_c     = rfData;
        if (hit) begin
            if (hitTnew == '0) begin
                sel_c  = hitSel;
                data_c = hitData;
            end else begin
                pend_c     = 1'b1;
                stallReq_c = (hitTnew > ENTRY_TW'(tuse));
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and stall control beside the D/E registers: shadows dst/Tnew of the
// in-flight E/M/W instructions and resolves every D-stage operand against them.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned NSRC = 2,
    parameter int unsigned TW   = 2
) (
    input logic               clk,
    input logic               rst_n,
    fwd_hazard_unit_if.slave  bus
);

    stageEntry_t        eStage;
    stageEntry_t        mStage;
    stageEntry_t        wStage;
    stageEntry_t        dEntry;
    logic [NSRC-1:0]    stallReq;
    logic               stallNow;
    logic [NSRC*DW-1:0] fwdData;
    logic [NSRC*2-1:0]  fwdSel;
    logic [NSRC-1:0]    fwdPend;
    logic [31:0]        stallCnt;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fwd_src_sel #(.DW(DW), .AW(AW), .TW(TW)) u_sel (
            .src        (bus.d_src[i*AW +: AW]),
            .tuse       (bus.d_tuse[i*TW +: TW]),
            .rfData     (bus.rf_data[i*DW +: DW]),
            .eData      (bus.e_data),
            .mData      (bus.m_data),
            .wData      (bus.w_data),
            .eStage     (eStage),
            .mStage     (mStage),
            .wStage     (wStage),
            .stallReq_c (stallReq[i]),
            .data_c     (fwdData[i*DW +: DW]),
            .sel_c      (fwdSel[i*2 +: 2]),
            .pend_c     (fwdPend[i])
        );
    end

    assign stallNow = bus.d_valid && (|stallReq);

    // A write to $0 is dropped on entry so it can never be matched.
    always_comb begin
        dEntry       = '0;
        dEntry.valid = bus.d_valid && (bus.d_dst != '0);
        dEntry.dst   = ENTRY_AW'(bus.d_dst);
        dEntry.tnew  = ENTRY_TW'(bus.d_tnew);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eStage <= '0;
            mStage <= '0;
            wStage <= '0;
        end else begin
            wStage <= ageEntry(mStage);
            mStage <= ageEntry(eStage);
            eStage <= stallNow ? stageEntry_t'('0) : dEntry;
        end
    end

    // Saturating stall-cycle counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (bus.stat_clr) begin
            stallCnt <= '0;
        end else if (stallNow && (stallCnt != 32'hFFFF_FFFF)) begin
            stallCnt <= stallCnt + 32'd1;
        end
    end

    assign bus.stall     = stallNow;
    assign bus.fwd_data  = fwdData;
    assign bus.fwd_sel   = fwdSel;
    assign bus.fwd_pend  = fwdPend;
    assign bus.stall_cnt = stallCnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed pipeline scenarios plus random traffic, checked
// against a model that tracks issued instructions by age since E entry.
module tb_fwd_hazard_unit;
    import fwd_hazard_unit_pkg::*;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NSRC = 2;
    localparam int unsigned TW   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.DW(DW), .AW(AW), .NSRC(NSRC), .TW(TW)) bus ();
    fwd_hazard_unit #(.DW(DW), .AW(AW), .NSRC(NSRC), .TW(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: slot k holds the instruction that entered E k cycles ago (k=0 is E).
    logic    mv[3];
    int      md[3];
    int      mt[3];
    longint  mcnt;
    logic    expStall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 3; k++) begin
            mv[k] = 1'b0; md[k] = 0; mt[k] = 0;
        end
        mcnt = 0;
    endtask

    function automatic void modelOperand(input int i, output logic st, output logic [1:0] sel,
                                         output logic pend, output logic [31:0] data);
        int   src;
        int   tuse;
        int   rem;
        logic found;
        logic [NSRC*AW-1:0] srcs;
        logic [NSRC*TW-1:0] tuses;
        logic [NSRC*DW-1:0] rfs;
        srcs  = bus.d_src;
        tuses = bus.d_tuse;
        rfs   = bus.rf_data;
        src   = int'(srcs[i*AW +: AW]);
        tuse  = int'(tuses[i*TW +: TW]);
        st    = 1'b0;
        sel   = 2'd0;
        pend  = 1'b0;
        data  = rfs[i*DW +: DW];
        found = 1'b0;
        if (src != 0) begin
            for (int k = 0; k < 3; k++) begin
                if (!found && mv[k] && md[k] == src) begin
                    found = 1'b1;
                    rem   = (mt[k] > k) ? mt[k] - k : 0;
                    if (rem == 0) begin
                        sel  = 2'(3 - k);
                        data = (k == 0) ? bus.e_data : (k == 1) ? bus.m_data : bus.w_data;
                    end else begin
                        pend = 1'b1;
                        st   = (rem > tuse);
                    end
                end
            end
        end
    endfunction

    task automatic checkNow(input string tag);
        logic        st[NSRC];
        logic [1:0]  sl[NSRC];
        logic        pd[NSRC];
        logic [31:0] dd[NSRC];
        logic [NSRC*2-1:0]  obsSel;
        logic [NSRC*DW-1:0] obsData;
        obsSel  = bus.fwd_sel;
        obsData = bus.fwd_data;
        for (int i = 0; i < NSRC; i++) modelOperand(i, st[i], sl[i], pd[i], dd[i]);
        expStall = bus.d_valid && (st[0] || st[1]);
        chk({tag, " stall"}, 64'(bus.stall), 64'(expStall));
        for (int i = 0; i < NSRC; i++) begin
            chk($sformatf("%s sel%0d", tag, i), 64'(obsSel[i*2 +: 2]), 64'(sl[i]));
            chk($sformatf("%s pend%0d", tag, i), 64'(bus.fwd_pend[i]), 64'(pd[i]));
            chk($sformatf("%s data%0d", tag, i), 64'(obsData[i*DW +: DW]), 64'(dd[i]));
        end
        chk({tag, " stall_cnt"}, 64'(bus.stall_cnt), 64'(mcnt));
    endtask

    task automatic look(input string tag);
        @(negedge clk);
        checkNow(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 2; k > 0; k--) begin
            mv[k] = mv[k-1]; md[k] = md[k-1]; mt[k] = mt[k-1];
        end
        mv[0] = !expStall && bus.d_valid && (bus.d_dst != '0);
        md[0] = int'(bus.d_dst);
        mt[0] = int'(bus.d_tnew);
        if (bus.stat_clr) mcnt = 0;
        else if (expStall && mcnt < 64'hFFFF_FFFF) mcnt = mcnt + 1;
        #1;
    endtask

    task automatic drive(input logic v, input int dst, input int tnew,
                         input int s0, input int s1, input int u0, input int u1);
        bus.d_valid  = v;
        bus.d_dst    = AW'(dst);
        bus.d_tnew   = TW'(tnew);
        bus.d_src    = {AW'(s1), AW'(s0)};
        bus.d_tuse   = {TW'(u1), TW'(u0)};
        bus.stat_clr = 1'b0;
    endtask

    initial begin
        logic [NSRC*2-1:0]  sv;
        logic [NSRC*DW-1:0] dv;
        modelReset();
        expStall = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 0, 0);
        bus.rf_data = {32'hAAAA_0001, 32'hAAAA_0000};
        bus.e_data  = 32'h0000_3008;
        bus.m_data  = 32'h0000_0011;
        bus.w_data  = 32'h0000_1234;

        repeat (2) @(posedge clk);
        #1;
        drive(1'b1, 0, 0, 3, 4, 0, 0);
        look("reset");
        chk("reset rf passthrough", 64'(bus.fwd_data), 64'({32'hAAAA_0001, 32'hAAAA_0000}));
        rst_n = 1'b1;
        tick();

        // add $3 then beq $3,$0
        drive(1'b1, 3, TNEW_ALU, 0, 0, 0, 0);
        look("add3");
        tick();
        drive(1'b1, 0, 0, 3, 0, TUSE_BRANCH, TUSE_BRANCH);
        look("beq stall");
        chk("beq stall high", 64'(bus.stall), 64'(1));
        tick();
        look("beq fwd M");
        sv = bus.fwd_sel;
        dv = bus.fwd_data;
        chk("beq sel M", 64'(sv[1:0]), 64'(FWD_M));
        chk("beq data M", 64'(dv[31:0]), 64'(32'h0000_0011));
        chk("beq cnt one", 64'(bus.stall_cnt), 64'(1));
        tick();

        // lw $5 then add $6,$5,$5
        drive(1'b1, 5, TNEW_LOAD, 0, 0, 0, 0);
        look("lw5");
        tick();
        drive(1'b1, 6, TNEW_ALU, 5, 5, TUSE_ALU, TUSE_ALU);
        look("load-use stall");
        chk("load-use stall high", 64'(bus.stall), 64'(1));
        tick();
        look("load-use pend");
        chk("load-use no stall", 64'(bus.stall), 64'(0));
        chk("load-use pend both", 64'(bus.fwd_pend), 64'(2'b11));
        tick();
        drive(1'b1, 7, TNEW_ALU, 5, 5, TUSE_ALU, TUSE_ALU);
        look("load W fwd");
        chk("load W sel", 64'(bus.fwd_sel), 64'({FWD_W, FWD_W}));
        chk("load W data", 64'(bus.fwd_data), 64'({32'h0000_1234, 32'h0000_1234}));
        tick();

        // jal then jr $31
        drive(1'b1, 31, TNEW_LINK, 0, 0, 0, 0);
        look("jal");
        tick();
        drive(1'b1, 0, 0, 31, 0, TUSE_BRANCH, TUSE_BRANCH);
        look("jr fwd E");
        sv = bus.fwd_sel;
        dv = bus.fwd_data;
        chk("jr sel E", 64'(sv[1:0]), 64'(FWD_E));
        chk("jr data E", 64'(dv[31:0]), 64'(32'h0000_3008));
        tick();

        // $0 as destination and source
        drive(1'b1, 0, TNEW_LINK, 0, 0, 0, 0);
        look("dst zero");
        tick();
        drive(1'b1, 0, 0, 0, 0, TUSE_BRANCH, TUSE_BRANCH);
        look("src zero");
        chk("src zero sel", 64'(bus.fwd_sel), 64'(0));
        chk("src zero data", 64'(bus.fwd_data), 64'({32'hAAAA_0001, 32'hAAAA_0000}));
        tick();

        // $4 in E (pending) and M (ready): the younger E copy wins
        drive(1'b1, 4, TNEW_ALU, 0, 0, 0, 0);
        look("w4 first");
        tick();
        drive(1'b1, 4, TNEW_ALU, 0, 0, 0, 0);
        look("w4 second");
        tick();
        drive(1'b1, 0, 0, 4, 0, TUSE_ALU, TUSE_STORE_DATA);
        look("youngest pending");
        chk("youngest no stall", 64'(bus.stall), 64'(0));
        chk("youngest pend", 64'(bus.fwd_pend[0]), 64'(1));
        chk("youngest sel rf", 64'(bus.fwd_sel), 64'(0));
        tick();

        // Random traffic over a small register window to force frequent matches
        for (int n = 0; n < 400; n++) begin
            drive(($urandom % 8) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
            bus.stat_clr = (($urandom % 32) == 0);
            bus.rf_data  = {$urandom, $urandom};
            bus.e_data   = $urandom;
            bus.m_data   = $urandom;
            bus.w_data   = $urandom;
            look("rand");
            tick();
        end

        // Stall accounting: 3 + 2 stall cycles, clear during a stall, reset mid-stall
        rst_n = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 1, 3, 0, 0, 0, 0);
        look("cnt prod1");
        tick();
        drive(1'b1, 0, 0, 1, 0, 0, 0);
        for (int n = 0; n < 4; n++) begin
            look("cnt ep1");
            tick();
        end
        drive(1'b1, 2, 2, 0, 0, 0, 0);
        look("cnt prod2");
        tick();
        drive(1'b1, 0, 0, 2, 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            look("cnt ep2");
            tick();
        end
        drive(1'b1, 1, 3, 0, 0, 0, 0);
        look("cnt prod3");
        chk("cnt five", 64'(bus.stall_cnt), 64'(5));
        tick();
        drive(1'b1, 0, 0, 1, 0, 0, 0);
        bus.stat_clr = 1'b1;
        look("cnt clr");
        chk("clr during stall", 64'(bus.stall), 64'(1));
        tick();
        bus.stat_clr = 1'b0;
        look("cnt after clr");
        chk("cnt cleared", 64'(bus.stall_cnt), 64'(0));
        chk("still stalling", 64'(bus.stall), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst stall drop", 64'(bus.stall), 64'(0));
        chk("rst cnt zero", 64'(bus.stall_cnt), 64'(0));
        chk("rst pend zero", 64'(bus.fwd_pend), 64'(0));
        modelReset();
        expStall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        look("post reset");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
